uart_rx_ctrl: RTL and testbench

UART receive frame sequencer. It synchronises the serial input, detects the start bit, and drives `rx_start`/`rx_done` to the existing sample-tick generator `rx_clk_gen`. It majority-votes the samples of every bit and assembles start, data, optional parity and stop into a byte with error flags. It sits between the pad-side `rxd` and the receive FIFO / register interface inside `uart_rx`.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 118 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receive-sequencer state encoding and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for rxd plus a delayed copy for falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd_i,
    output logic rxd_s_o,
    output logic fall_o
);

    logic s1_q, s2_q, dly_q;

    // Reset to the idle-high line level so release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            dly_q <= 1'b1;
        end else begin
            s1_q  <= rxd_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end

    assign rxd_s_o = s2_q;
    assign fall_o  = dly_q & ~s2_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer driving rx_clk_gen and assembling
// majority-voted bits into a byte with parity/frame error flags.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int SAMP_POINT = 9,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 sample_tick,
    output logic                 rx_start,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int M  = SAMP_POINT / 2;
    localparam int TW = $clog2(SAMP_POINT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LO   = TW'(M - 1);
    localparam logic [TW-1:0] T_MID  = TW'(M);
    localparam logic [TW-1:0] T_HI   = TW'(M + 1);
    localparam logic [TW-1:0] T_LAST = TW'(SAMP_POINT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD    = (PARITY_ODD != 0);

    rx_state_t             state_q;
    logic [TW-1:0]         tcnt_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_BITS-1:0]  shd_q, rx_data_q;
    logic                  v0_q, v1_q, v2_q, perr_q;
    logic                  rx_start_q, rx_done_q, rx_valid_q, parity_err_q, frame_err_q, busy_q;
    logic                  rxd_s, fall, vote, at_last;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd_i   (rxd),
        .rxd_s_o (rxd_s),
        .fall_o  (fall)
    );

    // The third sample is used live when the decision falls on the same tick (STOP, or SAMP_POINT = 3).
    assign vote    = maj3(v0_q, v1_q, tcnt_q == T_HI ? rxd_s : v2_q);
    assign at_last = sample_tick && tcnt_q == T_LAST;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q      <= IDLE;
            tcnt_q       <= '0;
            bit_q        <= '0;
            shd_q        <= '0;
            rx_data_q    <= '0;
            {v0_q, v1_q, v2_q, perr_q} <= '0;
            {rx_start_q, rx_done_q, rx_valid_q, parity_err_q, frame_err_q, busy_q} <= '0;
        end else begin
            rx_start_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            if (state_q != IDLE && sample_tick) begin
                tcnt_q <= tcnt_q == T_LAST ? '0 : tcnt_q + 1'b1;
                if (tcnt_q == T_LO)  v0_q <= rxd_s;
                if (tcnt_q == T_MID) v1_q <= rxd_s;
                if (tcnt_q == T_HI)  v2_q <= rxd_s;
            end
            case (state_q)
                IDLE: if (fall) begin
                    rx_start_q <= 1'b1;
                    busy_q     <= 1'b1;
                    tcnt_q     <= '0;
                    bit_q      <= '0;
                    perr_q     <= 1'b0;
                    state_q    <= START;
                end
                START: if (at_last) begin
                    if (vote) begin
                        rx_done_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else state_q <= DATA;
                end
                DATA: if (at_last) begin
                    shd_q <= {vote, shd_q[DATA_BITS-1:1]};
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == B_LAST) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: if (at_last) begin
                    perr_q  <= ^shd_q ^ vote ^ ODD;
                    state_q <= STOP;
                end
                STOP: if (sample_tick && tcnt_q == T_HI) begin
                    rx_done_q    <= 1'b1;
                    rx_valid_q   <= 1'b1;
                    rx_data_q    <= shd_q;
                    parity_err_q <= perr_q;
                    frame_err_q  <= ~vote;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end

    assign rx_start   = rx_start_q;
    assign rx_done    = rx_done_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames with a scoreboard of expected bytes and error flags.
module tb_uart_rx_ctrl;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, rxd, sample_tick;
    logic       rx_start, rx_done, rx_valid, parity_err, frame_err, busy;
    logic [7:0] rx_data;

    exp_t q[$];
    int   total = 0, bad = 0;
    int   cyc = 0, fall_cyc = 0;
    int   start_cnt = 0, done_cnt = 0, valid_cnt = 0;

    uart_rx_ctrl #(.SAMP_POINT(9), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .sample_tick(sample_tick),
        .rx_start   (rx_start),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (7) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_fall();
        rxd      = 1'b0;
        fall_cyc = cyc;
    endtask

    // glitch_bit >= 0 puts a one-tick high pulse at the mid sample of that data bit
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int glitch_bit);
        exp_t e;
        e.d = (glitch_bit >= 0) ? (d & ~(8'd1 << glitch_bit)) : d;
        e.p = ^e.d ^ p;
        e.f = ~s;
        q.push_back(e);
        drive_fall();
        tick(9);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (i == glitch_bit) begin
                rxd = 1'b0;
                tick(4);
                rxd = 1'b1;
                tick(1);
                rxd = 1'b0;
                tick(4);
            end else tick(9);
        end
        rxd = p;
        tick(9);
        rxd = s;
        tick(9);
    endtask

    always @(negedge clk) begin
        if (rx_start) begin
            start_cnt++;
            chk("start_latency", cyc - fall_cyc, 3);
        end
        if (rx_done) begin
            done_cnt++;
            chk("start_done_overlap", {31'd0, rx_start}, 0);
        end
        if (rx_valid) begin
            valid_cnt++;
            if (q.size() == 0) chk("valid_without_frame", q.size(), 1);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                chk("parity_err", {31'd0, parity_err}, {31'd0, e.p});
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.f});
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st0, dn0, vl0;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rx_start, rx_done, rx_valid, parity_err, frame_err, busy, rx_data}, 0);
        rst_n = 1'b1;
        tick(3);

        send_frame(8'hA5, 1'b0, 1'b1, -1);
        tick(3);
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        tick(3);
        send_frame(8'h00, 1'b0, 1'b1, 3);
        tick(3);

        dn0 = done_cnt;
        vl0 = valid_cnt;
        drive_fall();
        tick(2);
        rxd = 1'b1;
        tick(12);
        chk("glitch_start_done", done_cnt - dn0, 1);
        chk("glitch_start_no_valid", valid_cnt - vl0, 0);
        chk("glitch_start_idle", {31'd0, busy}, 0);

        st0 = start_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        tick(20);
        chk("ferr_low_no_restart", start_cnt - st0, 1);
        rxd = 1'b1;
        tick(18);
        chk("ferr_high_no_restart", start_cnt - st0, 1);
        send_frame(8'h0F, 1'b0, 1'b1, -1);
        chk("ferr_new_edge_restart", start_cnt - st0, 2);
        tick(3);

        vl0 = valid_cnt;
        drive_fall();
        tick(9);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            tick(9);
        end
        rxd = 1'b0;
        tick(3);
        chk("busy_mid_frame", {31'd0, busy}, 1);
        rst_n = 1'b0;
        rxd   = 1'b1;
        #1;
        chk("midframe_reset_outputs", {rx_start, rx_done, rx_valid, parity_err, frame_err, busy, rx_data}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(20);
        chk("midframe_reset_no_valid", valid_cnt - vl0, 0);
        chk("midframe_reset_idle", {31'd0, busy}, 0);
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        tick(12);

        chk("scoreboard_drained", q.size(), 0);
        chk("valid_total", valid_cnt, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
